// File: rtl/call_return_ctrl_if.sv
// Bundle between the call/return controller, the decode stage, fetch and the
// 8-entry return-address stack.
interface call_return_ctrl_if #(
   parameter int AW = 12,
   parameter int CW = 4
);
   logic          call_valid;
   logic          ret_valid;
   logic [AW-1:0] pc;
   logic [AW-1:0] call_target;
   logic          stall;
   logic          flush;
   logic [AW-1:0] stk_data;
   logic          stk_push;
   logic          stk_pop;
   logic [AW-1:0] stk_addr_in;
   logic          redirect_valid;
   logic [AW-1:0] redirect_pc;
   logic          busy;
   logic [CW-1:0] depth;
   logic          overflow_err;
   logic          underflow_err;

   modport master (
      input  call_valid, ret_valid, pc, call_target, stall, flush, stk_data,
      output stk_push, stk_pop, stk_addr_in, redirect_valid, redirect_pc,
             busy, depth, overflow_err, underflow_err
   );

   modport slave (
      output call_valid, ret_valid, pc, call_target, stall, flush, stk_data,
      input  stk_push, stk_pop, stk_addr_in, redirect_valid, redirect_pc,
             busy, depth, overflow_err, underflow_err
   );
endinterface

// File: rtl/call_return_ctrl.sv
// Call/return controller: drives push/pop pulses to the return-address stack,
// redirects fetch, tracks occupancy and flags overflow/underflow.
module call_return_ctrl #(
   parameter int AW    = 12,
   parameter int DEPTH = 8,
   parameter int CW    = 4
) (
   input  logic               clk,
   input  logic               rst,
   call_return_ctrl_if.master bus
);

   localparam logic [1:0] S_IDLE       = 2'd0;
   localparam logic [1:0] S_CALL_ISSUE = 2'd1;
   localparam logic [1:0] S_RET_POP    = 2'd2;
   localparam logic [1:0] S_RET_WAIT   = 2'd3;

   localparam logic [CW-1:0] DEPTH_FULL = CW'(DEPTH);

   logic [1:0]    r_state;
   logic [1:0]    w_state_nxt;
   logic          r_busy;
   logic [CW-1:0] r_depth;
   logic          r_ovf;
   logic          r_unf;
   logic          r_push;
   logic          r_pop;
   logic [AW-1:0] r_addr;
   logic          r_rv;
   logic [AW-1:0] r_rpc;
   logic          r_ret_done;

   logic          w_accept;
   logic          w_has_entry;
   logic          w_has_room;
   logic [AW-1:0] w_pc_inc;

   assign w_accept    = (r_state == S_IDLE) && !bus.stall && (bus.call_valid || bus.ret_valid);
   assign w_has_entry = (r_depth != '0);
   assign w_has_room  = (r_depth < DEPTH_FULL);
   assign w_pc_inc    = bus.pc + AW'(1);

   // Overflowing calls and underflowing returns redirect in one cycle, so both
   // reuse the single-cycle issue state; only a real pop walks RET_POP/RET_WAIT.
   always_comb begin
      // NOTE: default first so every path assigns w_state_nxt and no latch is inferred.
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept)
               w_state_nxt = (!bus.call_valid && w_has_entry) ? S_RET_POP : S_CALL_ISSUE;
         end
         S_CALL_ISSUE: w_state_nxt = S_IDLE;
         S_RET_POP:    w_state_nxt = bus.flush ? S_IDLE : S_RET_WAIT;
         S_RET_WAIT: begin
            if (bus.flush || r_ret_done)
               w_state_nxt = S_IDLE;
         end
         default:      w_state_nxt = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only; strobes default
   // low each cycle so every set below is exactly a one-cycle pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_busy     <= 1'b0;
         r_depth    <= '0;
         r_ovf      <= 1'b0;
         r_unf      <= 1'b0;
         r_push     <= 1'b0;
         r_pop      <= 1'b0;
         r_addr     <= '0;
         r_rv       <= 1'b0;
         r_rpc      <= '0;
         r_ret_done <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_busy  <= (w_state_nxt != S_IDLE);
         r_push  <= 1'b0;
         r_pop   <= 1'b0;
         r_rv    <= 1'b0;

         if (w_accept) begin
            if (bus.call_valid) begin
               r_rv  <= 1'b1;
               r_rpc <= bus.call_target;
               if (w_has_room) begin
                  r_push  <= 1'b1;
                  r_addr  <= w_pc_inc;
                  r_depth <= r_depth + CW'(1);
               end else begin
                  r_ovf <= 1'b1;
               end
            end else if (w_has_entry) begin
               r_pop   <= 1'b1;
               r_depth <= r_depth - CW'(1);
            end else begin
               r_unf <= 1'b1;
               r_rv  <= 1'b1;
               r_rpc <= w_pc_inc;
            end
         end

         // Stack data arrives during the first RET_WAIT cycle; the redirect is
         // presented in the second one, after which the FSM drops to IDLE.
         if (r_state == S_RET_WAIT) begin
            if (!bus.flush && !r_ret_done) begin
               r_rv       <= 1'b1;
               r_rpc      <= bus.stk_data;
               r_ret_done <= 1'b1;
            end else begin
               r_ret_done <= 1'b0;
            end
         end
      end
   end

   assign bus.stk_push       = r_push;
   assign bus.stk_pop        = r_pop;
   assign bus.stk_addr_in    = r_addr;
   assign bus.redirect_valid = r_rv;
   assign bus.redirect_pc    = r_rpc;
   assign bus.busy           = r_busy;
   assign bus.depth          = r_depth;
   assign bus.overflow_err   = r_ovf;
   assign bus.underflow_err  = r_unf;

endmodule

// File: tb/tb_call_return_ctrl.sv
// Randomised scoreboard bench for call_return_ctrl: a LIFO reference model
// predicts every stack strobe and redirect, including its cycle.
module tb_call_return_ctrl;

   typedef struct packed {
      logic        push;
      logic        pop;
      logic        rv;
      logic [11:0] addr;
      logic [11:0] rpc;
      logic [3:0]  depth;
      logic        ovf;
      logic        unf;
      logic [31:0] cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   call_return_ctrl_if bus ();

   call_return_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] cyc = 0;
   bit          rst_seen = 1'b0;

   always @(posedge clk) begin
      cyc      = cyc + 1;
      rst_seen = rst;
   end

   // Reference model state
   exp_t        sb[$];
   logic [11:0] m_stack[$];
   int          m_depth = 0;
   logic        m_ovf = 1'b0;
   logic        m_unf = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Behavioural return-address stack: pops appear on stk_data one cycle later,
   // other cycles carry junk so a mistimed sample is visible.
   logic [11:0] ras[$];
   bit          pend = 1'b0;
   logic [11:0] pend_val = '0;

   always @(negedge clk) begin
      if (rst_seen) begin
         ras.delete();
         pend         = 1'b0;
         bus.stk_data = 12'($urandom);
      end else begin
         bus.stk_data = pend ? pend_val : 12'($urandom);
         pend = 1'b0;
         if (bus.stk_pop) begin
            pend     = 1'b1;
            pend_val = (ras.size() > 0) ? ras.pop_back() : 12'($urandom);
         end
         if (bus.stk_push)
            ras.push_back(bus.stk_addr_in);
      end
   end

   // Monitor: every cycle showing a strobe must match the next expectation.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && (bus.stk_push || bus.stk_pop || bus.redirect_valid)) begin
         if (sb.size() == 0) begin
            check("unexpected_strobe", {29'd0, bus.stk_push, bus.stk_pop, bus.redirect_valid}, 32'd0);
         end else begin
            e = sb.pop_front();
            check("strobe_cycle", cyc, e.cyc);
            check("strobes", {29'd0, bus.stk_push, bus.stk_pop, bus.redirect_valid},
                  {29'd0, e.push, e.pop, e.rv});
            if (e.push) check("push_addr", 32'(bus.stk_addr_in), 32'(e.addr));
            if (e.rv)   check("redirect_pc", 32'(bus.redirect_pc), 32'(e.rpc));
            check("depth", 32'(bus.depth), 32'(e.depth));
            check("err_flags", {30'd0, bus.overflow_err, bus.underflow_err}, {30'd0, e.ovf, e.unf});
         end
      end
   end

   function automatic exp_t mk(input logic push, input logic pop, input logic rv,
                               input logic [11:0] addr, input logic [11:0] rpc,
                               input logic [31:0] c);
      exp_t e;
      e.push  = push;
      e.pop   = pop;
      e.rv    = rv;
      e.addr  = addr;
      e.rpc   = rpc;
      e.depth = 4'(m_depth);
      e.ovf   = m_ovf;
      e.unf   = m_unf;
      e.cyc   = c;
      return e;
   endfunction

   task automatic idle_inputs();
      bus.call_valid  = 1'b0;
      bus.ret_valid   = 1'b0;
      bus.stall       = 1'b0;
      bus.flush       = 1'b0;
      bus.pc          = 12'($urandom);
      bus.call_target = 12'($urandom);
   endtask

   // Events offered while busy must be ignored.
   task automatic garbage(input bit allow_flush);
      bus.call_valid  = 1'($urandom);
      bus.ret_valid   = 1'($urandom);
      bus.stall       = 1'($urandom);
      bus.flush       = allow_flush ? 1'($urandom) : 1'b0;
      bus.pc          = 12'($urandom);
      bus.call_target = 12'($urandom);
   endtask

   task automatic model_reset();
      sb.delete();
      m_stack.delete();
      m_depth = 0;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
   endtask

   task automatic check_zero();
      check("rst_push",     32'(bus.stk_push), 0);
      check("rst_pop",      32'(bus.stk_pop), 0);
      check("rst_addr",     32'(bus.stk_addr_in), 0);
      check("rst_rv",       32'(bus.redirect_valid), 0);
      check("rst_rpc",      32'(bus.redirect_pc), 0);
      check("rst_busy",     32'(bus.busy), 0);
      check("rst_depth",    32'(bus.depth), 0);
      check("rst_overflow", 32'(bus.overflow_err), 0);
      check("rst_underflow", 32'(bus.underflow_err), 0);
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      idle_inputs();
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      check_zero();
   endtask

   task automatic do_call(input logic [11:0] pc, input logic [11:0] tgt, input bit both);
      logic [31:0] c0;
      c0 = cyc;
      check("busy_before_call", 32'(bus.busy), 0);
      bus.call_valid  = 1'b1;
      bus.ret_valid   = both;
      bus.stall       = 1'b0;
      bus.flush       = 1'b0;
      bus.pc          = pc;
      bus.call_target = tgt;
      if (m_depth < 8) begin
         m_stack.push_back(pc + 12'd1);
         m_depth++;
         sb.push_back(mk(1'b1, 1'b0, 1'b1, pc + 12'd1, tgt, c0 + 1));
      end else begin
         m_ovf = 1'b1;
         sb.push_back(mk(1'b0, 1'b0, 1'b1, 12'd0, tgt, c0 + 1));
      end
      @(negedge clk);
      check("busy_call_issue", 32'(bus.busy), 1);
      garbage(1'b1);
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic do_ret(input logic [11:0] pc, input int flush_at, input bit rst_mid);
      logic [31:0] c0;
      logic [11:0] a;
      c0 = cyc;
      check("busy_before_ret", 32'(bus.busy), 0);
      bus.call_valid = 1'b0;
      bus.ret_valid  = 1'b1;
      bus.stall      = 1'b0;
      bus.flush      = 1'b0;
      bus.pc         = pc;
      if (m_depth == 0) begin
         m_unf = 1'b1;
         sb.push_back(mk(1'b0, 1'b0, 1'b1, 12'd0, pc + 12'd1, c0 + 1));
         @(negedge clk);
         check("busy_underflow", 32'(bus.busy), 1);
         garbage(1'b1);
         @(negedge clk);
         idle_inputs();
         return;
      end
      a = m_stack.pop_back();
      m_depth--;
      sb.push_back(mk(1'b0, 1'b1, 1'b0, 12'd0, 12'd0, c0 + 1));
      if (flush_at == 0 && !rst_mid)
         sb.push_back(mk(1'b0, 1'b0, 1'b1, 12'd0, a, c0 + 3));
      @(negedge clk);
      check("busy_ret_pop", 32'(bus.busy), 1);
      garbage(1'b0);
      if (flush_at == 1) begin
         bus.flush = 1'b1;
         @(negedge clk);
         check("busy_after_flush_pop", 32'(bus.busy), 0);
         idle_inputs();
         return;
      end
      @(negedge clk);
      check("busy_ret_wait", 32'(bus.busy), 1);
      garbage(1'b0);
      if (flush_at == 2) begin
         bus.flush = 1'b1;
         @(negedge clk);
         check("busy_after_flush_wait", 32'(bus.busy), 0);
         idle_inputs();
         return;
      end
      if (rst_mid) begin
         rst = 1'b1;
         @(negedge clk);
         rst = 1'b0;
         idle_inputs();
         model_reset();
         check_zero();
         return;
      end
      @(negedge clk);
      check("busy_ret_redirect", 32'(bus.busy), 1);
      garbage(1'b0);
      @(negedge clk);
      check("busy_after_ret", 32'(bus.busy), 0);
      idle_inputs();
   endtask

   task automatic do_stalled();
      bit pick;
      pick = 1'($urandom);
      check("busy_before_stall", 32'(bus.busy), 0);
      bus.call_valid = pick;
      bus.ret_valid  = !pick || 1'($urandom);
      bus.stall      = 1'b1;
      @(negedge clk);
      check("stall_ignored", 32'(bus.busy), 0);
      idle_inputs();
   endtask

   function automatic logic [11:0] rand_pc();
      return ($urandom_range(0, 7) == 0) ? 12'hFFF : 12'($urandom);
   endfunction

   initial begin
      int r;
      int f;
      rst = 1'b1;
      idle_inputs();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      model_reset();
      check_zero();

      // Basic call then matching return
      do_call(12'h010, 12'h200, 1'b0);
      do_ret(12'h205, 0, 1'b0);
      check("depth_after_pair", 32'(bus.depth), 32'(m_depth));

      // Underflow with wrapping fall-through
      do_ret(12'hFFF, 0, 1'b0);
      check("underflow_flag", 32'(bus.underflow_err), 1);

      // Fill the stack and overflow once
      apply_reset();
      for (int i = 0; i < 9; i++)
         do_call(12'h100 + 12'(i), 12'($urandom), 1'b0);
      check("full_depth", 32'(bus.depth), 8);
      check("overflow_flag", 32'(bus.overflow_err), 1);

      // Simultaneous call/return, flush in RET_WAIT, reset in RET_WAIT
      apply_reset();
      do_call(12'($urandom), 12'($urandom), 1'b0);
      do_call(12'($urandom), 12'($urandom), 1'b0);
      do_call(12'($urandom), 12'($urandom), 1'b1);
      check("depth_call_wins", 32'(bus.depth), 3);
      do_ret(12'($urandom), 2, 1'b0);
      check("depth_after_flush", 32'(bus.depth), 2);
      do_ret(12'($urandom), 0, 1'b1);

      // Random traffic
      for (int n = 0; n < 300; n++) begin
         r = $urandom_range(0, 9);
         if (r < 4) begin
            do_call(rand_pc(), 12'($urandom), $urandom_range(0, 3) == 0);
         end else if (r < 8) begin
            f = $urandom_range(0, 5);
            do_ret(rand_pc(), (f == 4) ? 1 : ((f == 5) ? 2 : 0), 1'b0);
         end else if (r == 8) begin
            do_stalled();
         end else begin
            check("busy_idle", 32'(bus.busy), 0);
            @(negedge clk);
         end
      end

      repeat (4) @(negedge clk);
      check("scoreboard_drained", 32'(sb.size()), 0);
      check("final_depth", 32'(bus.depth), 32'(m_depth));
      check("final_overflow", 32'(bus.overflow_err), 32'(m_ovf));
      check("final_underflow", 32'(bus.underflow_err), 32'(m_unf));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
